priority_enc4_2_beh_ifelse: RTL and testbench
=============================================

PRIORITY_ENC4_2_BEH_IFELSE -- requirements
Module: priority_enc4_2_beh_ifelse

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  encoder enable; when 0, no request is encoded.
REQ-006 I3  input  1  request line 3, highest priority.
REQ-007 I2  input  1  request line 2.
REQ-008 I1  input  1  request line 1.
REQ-009 I0  input  1  request line 0, lowest priority.
REQ-010 O1  output  1  encoded index, MSB, registered.
REQ-011 O0  output  1  encoded index, LSB, registered.
REQ-012 V  output  1  valid, registered: 1 when the registered {O1,O0} encodes an active request.

Function
REQ-013 All outputs SHALL be driven directly from flip-flops; there SHALL be no combinational input-to-output path.
REQ-014 Inputs sampled at rising edge N SHALL appear on O1, O0 and V after edge N, giving 1-cycle latency.
REQ-015 The encode SHALL be a strict if/else-if priority chain: I3, then I2, then I1, then I0.
REQ-016 When en=1 and I3=1, {O1,O0} SHALL be 2'b11 and V=1, regardless of I2..I0.
REQ-017 When en=1, I3=0 and I2=1, {O1,O0} SHALL be 2'b10 and V=1, regardless of I1 and I0.
REQ-018 When en=1, I3=I2=0 and I1=1, {O1,O0} SHALL be 2'b01 and V=1, regardless of I0.
REQ-019 When en=1, I3=I2=I1=0 and I0=1, {O1,O0} SHALL be 2'b00 and V=1.
REQ-020 When en=1 and all requests are 0, {O1,O0} SHALL be 2'b00 and V=0.
REQ-021 When en=0, {O1,O0} SHALL be 2'b00 and V=0, regardless of I3..I0.
REQ-022 Simultaneous requests SHALL resolve only to the highest-priority asserted line.
REQ-023 Outputs SHALL be updated every cycle; there is no hold or stall behaviour.
REQ-024 X/Z on any input SHALL NOT be specially handled, and a bench SHALL drive known values.
REQ-025 In simulation, outputs SHALL stay X until the first reset or the first clock edge, and a bench SHALL NOT check them before then.

Reset
REQ-026 On a rising clk edge with rst=1, O1, O0 and V SHALL all become 0.
REQ-027 rst SHALL take priority over en and all request inputs at that edge.
REQ-028 rst asserted in the middle of a sequence SHALL clear the outputs at the next edge.
REQ-029 On the first edge after rst deasserts, the outputs SHALL reflect the inputs sampled at that edge.
REQ-030 Deasserting or asserting rst between clock edges SHALL have no effect on the outputs.

Verification
REQ-031 Reset: rst=1 for 2 cycles with en=1, I3=1 -> O1=0, O0=0, V=0.
REQ-032 Disabled encoder: en=0, I3..I0=1000 -> next cycle O1O0=00, V=0.
REQ-033 Single request, lowest line: en=1, I3..I0=0001 -> next cycle O1O0=00, V=1.
REQ-034 Single request, line 1: en=1, I3..I0=0010 -> next cycle O1O0=01, V=1.
REQ-035 Priority between I2 and I0: en=1, I3..I0=0101 -> next cycle O1O0=10, V=1.
REQ-036 Highest line, then idle: en=1, I3..I0=1000 -> O1O0=11, V=1; then en=1, I3..I0=0000 -> O1O0=00, V=0.
REQ-037 A bench SHALL sweep all 32 (en, I3..I0) combinations against a reference model, checking each result one cycle later.

Source files
------------

// File: rtl/priority_enc4_2_beh_ifelse.sv
// 4-to-2 priority encoder with registered outputs.
// I3 has the highest priority and I0 the lowest. The encoded index and the
// valid flag are captured on every rising clk edge, so results appear one
// cycle after the inputs are sampled. No input reaches an output without
// passing through a flop.
module priority_enc4_2_beh_ifelse (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic I3,
  input  logic I2,
  input  logic I1,
  input  logic I0,
  output logic O1,
  output logic O0,
  output logic V
);

  logic [1:0] idx_d;
  logic [1:0] idx_q;
  logic       valid_d;
  logic       valid_q;

  // Priority chain: the first asserted line, starting from I3, wins.
  // Both the disabled case and the no-request case encode 2'b00 with valid low.
  always_comb begin
    idx_d   = 2'b00;
    valid_d = 1'b0;
    if (en) begin
      if (I3) begin
        idx_d   = 2'b11;
        valid_d = 1'b1;
      end else if (I2) begin
        idx_d   = 2'b10;
        valid_d = 1'b1;
      end else if (I1) begin
        idx_d   = 2'b01;
        valid_d = 1'b1;
      end else if (I0) begin
        idx_d   = 2'b00;
        valid_d = 1'b1;
      end
    end
  end

  // Output registers: reset overrides every other input; otherwise they update every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign O1 = idx_q[1];
  assign O0 = idx_q[0];
  assign V  = valid_q;

endmodule

// File: tb/tb_priority_enc4_2_beh_ifelse.sv
// Directed bench for the registered 4-to-2 priority encoder.
// Inputs are driven on the falling edge, and outputs are sampled on the falling
// edge that follows the next rising edge.
module tb_priority_enc4_2_beh_ifelse;

  logic clk;
  logic rst;
  logic en;
  logic I3, I2, I1, I0;
  logic O1, O0, V;

  int tests;
  int fails;

  priority_enc4_2_beh_ifelse dut (
    .clk(clk), .rst(rst), .en(en),
    .I3(I3), .I2(I2), .I1(I1), .I0(I0),
    .O1(O1), .O0(O0), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs at a falling edge, then move past one rising edge to the next falling edge.
  task automatic step(input logic r, input logic e, input logic [3:0] req);
    @(negedge clk);
    rst = r;
    en = e;
    {I3, I2, I1, I0} = req;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 4'b1000);
    step(1'b1, 1'b1, 4'b1000);
    tests++;
    if ({O1, O0, V} !== 3'b000) begin
      fails++;
      $display("FAIL reset: got O1O0V=%b expected 000", {O1, O0, V});
    end
    $display("[TB] reset O1O0V=%b", {O1, O0, V});
  endtask

  task automatic test_directed();
    logic       e_tab   [6];
    logic [3:0] req_tab [6];
    logic [2:0] exp_tab [6];
    e_tab[0] = 1'b0; req_tab[0] = 4'b1000; exp_tab[0] = 3'b000;
    e_tab[1] = 1'b1; req_tab[1] = 4'b0001; exp_tab[1] = 3'b001;
    e_tab[2] = 1'b1; req_tab[2] = 4'b0010; exp_tab[2] = 3'b011;
    e_tab[3] = 1'b1; req_tab[3] = 4'b0101; exp_tab[3] = 3'b101;
    e_tab[4] = 1'b1; req_tab[4] = 4'b1000; exp_tab[4] = 3'b111;
    e_tab[5] = 1'b1; req_tab[5] = 4'b0000; exp_tab[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, e_tab[i], req_tab[i]);
      tests++;
      if ({O1, O0, V} !== exp_tab[i]) begin
        fails++;
        $display("FAIL directed[%0d]: en=%b req=%b got O1O0V=%b expected %b",
                 i, e_tab[i], req_tab[i], {O1, O0, V}, exp_tab[i]);
      end
      $display("[TB] directed[%0d] en=%b req=%b O1O0V=%b", i, e_tab[i], req_tab[i], {O1, O0, V});
    end
  endtask

  task automatic test_back_to_back();
    // 1100 then 0011 in consecutive cycles must change the output on every cycle.
    step(1'b0, 1'b1, 4'b1100);
    tests++;
    if ({O1, O0, V} !== 3'b111) begin
      fails++;
      $display("FAIL b2b_first: got O1O0V=%b expected 111", {O1, O0, V});
    end
    step(1'b0, 1'b1, 4'b0011);
    tests++;
    if ({O1, O0, V} !== 3'b011) begin
      fails++;
      $display("FAIL b2b_second: got O1O0V=%b expected 011", {O1, O0, V});
    end
    $display("[TB] back_to_back O1O0V=%b", {O1, O0, V});
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b1, 4'b0100);
    step(1'b1, 1'b1, 4'b0100);
    tests++;
    if ({O1, O0, V} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset: got O1O0V=%b expected 000", {O1, O0, V});
    end
    // The first edge after reset is released must already encode the inputs.
    step(1'b0, 1'b1, 4'b0100);
    tests++;
    if ({O1, O0, V} !== 3'b101) begin
      fails++;
      $display("FAIL post_reset: got O1O0V=%b expected 101", {O1, O0, V});
    end
    // A reset pulse that begins and ends between edges must be ignored.
    @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({O1, O0, V} !== 3'b101) begin
      fails++;
      $display("FAIL glitch_reset: got O1O0V=%b expected 101", {O1, O0, V});
    end
    $display("[TB] mid_reset O1O0V=%b", {O1, O0, V});
  endtask

  task automatic test_sweep();
    logic [2:0] expv;
    for (int k = 0; k < 32; k++) begin
      logic       e;
      logic [3:0] req;
      e   = k[4];
      req = k[3:0];
      // Reference model: scan downward from the top line and stop at the first set bit.
      expv = 3'b000;
      if (e) begin
        for (int b = 3; b >= 0; b--) begin
          if (req[b] && expv[0] == 1'b0) begin
            expv = {b[1:0], 1'b1};
          end
        end
      end
      step(1'b0, e, req);
      tests++;
      if ({O1, O0, V} !== expv) begin
        fails++;
        $display("FAIL sweep: en=%b req=%b got O1O0V=%b expected %b", e, req, {O1, O0, V}, expv);
      end
      $display("[TB] sweep en=%b req=%b O1O0V=%b", e, req, {O1, O0, V});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    en = 1'b0;
    {I3, I2, I1, I0} = 4'b0000;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
